// File: rtl/join_pkg.sv
// Shared helpers for the join_buf elastic join: pointer sizing and counter width.
package join_pkg;

  localparam int CNT_W = 32;

  // Ceiling log2, usable in constant expressions for parameter-derived widths.
  function automatic int clog2_f(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // FIFO pointers carry one extra wrap bit above the address bits.
  function automatic int ptr_w_f(input int depth);
    return clog2_f(depth) + 1;
  endfunction

endpackage

// File: rtl/join_fifo.sv
// Per-channel FIFO for join_buf: wrap-bit pointers, registered ready, head read from state.
module join_fifo
  import join_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic              o_empty
);

  localparam int PTR_W  = ptr_w_f(DEPTH);
  localparam int ADDR_W = PTR_W - 1;

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                   (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_ready = !w_full;
  assign w_push  = i_valid && !w_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr[ADDR_W-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // NOTE: the storage is reset on purpose, since the head is visible on io_dout and must read 0 out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_data;
    end
  end

endmodule

// File: rtl/join_buf.sv
// N-input elastic join: one FIFO per channel, all channels pop together on fire.
// Optional statistics counters are enabled with the JOIN_STATS_EN macro.
module join_buf
  import join_pkg::*;
#(
  parameter int NUM_IN = 2,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_IN*DATA_W-1:0] io_din,
  input  logic [NUM_IN-1:0]        io_din_v,
  output logic [NUM_IN-1:0]        io_din_r,
  output logic [NUM_IN*DATA_W-1:0] io_dout,
  output logic                     io_dout_v,
  input  logic                     io_dout_r
`ifdef JOIN_STATS_EN
  ,
  output logic [CNT_W-1:0]         io_fire_cnt,
  output logic [CNT_W-1:0]         io_stall_cnt
`endif
);

  logic [NUM_IN-1:0] w_empty;
  logic              w_fire;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_ch
    join_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .i_data  (io_din[g*DATA_W +: DATA_W]),
      .i_valid (io_din_v[g]),
      .o_ready (io_din_r[g]),
      .i_pop   (w_fire),
      .o_head  (io_dout[g*DATA_W +: DATA_W]),
      .o_empty (w_empty[g])
    );
  end

  assign io_dout_v = &(~w_empty);
  assign w_fire    = io_dout_v && io_dout_r;

`ifdef JOIN_STATS_EN
  logic [CNT_W-1:0] r_fire_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fire_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_fire && (r_fire_cnt != '1))
        r_fire_cnt <= r_fire_cnt + CNT_W'(1);
      if (io_dout_v && !io_dout_r && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign io_fire_cnt  = r_fire_cnt;
  assign io_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_join_buf.sv
// Randomized and directed bench for join_buf against a queue-based model of the join.
module tb_join_buf;

  localparam int NUM_IN = 2;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2;

  logic                     clock;
  logic                     reset;
  logic [NUM_IN*DATA_W-1:0] io_din;
  logic [NUM_IN-1:0]        io_din_v;
  logic [NUM_IN-1:0]        io_din_r;
  logic [NUM_IN*DATA_W-1:0] io_dout;
  logic                     io_dout_v;
  logic                     io_dout_r;
`ifdef JOIN_STATS_EN
  logic [31:0]              io_fire_cnt;
  logic [31:0]              io_stall_cnt;
`endif

  join_buf #(
    .NUM_IN (NUM_IN),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .io_din    (io_din),
    .io_din_v  (io_din_v),
    .io_din_r  (io_din_r),
    .io_dout   (io_dout),
    .io_dout_v (io_dout_v),
    .io_dout_r (io_dout_r)
`ifdef JOIN_STATS_EN
    ,
    .io_fire_cnt  (io_fire_cnt),
    .io_stall_cnt (io_stall_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_total = 0;
  int n_bad   = 0;

  // Model: one bounded queue per channel, plus expected statistics.
  logic [DATA_W-1:0] mdl_q [NUM_IN][$];
  int                mdl_fire  = 0;
  int                mdl_stall = 0;
  logic [NUM_IN-1:0] last_push;
  int                fire_seen = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge: drive one cycle, check outputs, advance the model at the rising edge.
  task automatic step(input logic [NUM_IN-1:0] din_v, input logic [NUM_IN*DATA_W-1:0] din,
                      input logic dout_r);
    logic [NUM_IN-1:0]        exp_r;
    logic                     exp_v;
    logic [NUM_IN*DATA_W-1:0] exp_dout;
    exp_v    = 1'b1;
    exp_dout = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      exp_r[i] = (mdl_q[i].size() < DEPTH);
      if (mdl_q[i].size() == 0) exp_v = 1'b0;
      else exp_dout[i*DATA_W +: DATA_W] = mdl_q[i][0];
    end
    io_din_v  = din_v;
    io_din    = din;
    io_dout_r = dout_r;
    #1;
    check("din_r", io_din_r, exp_r);
    check("dout_v", io_dout_v, exp_v);
    if (exp_v) check("dout", io_dout, exp_dout);
`ifdef JOIN_STATS_EN
    check("fire_cnt", io_fire_cnt, mdl_fire);
    check("stall_cnt", io_stall_cnt, mdl_stall);
`endif
    if (io_dout_v && io_dout_r) fire_seen++;
    @(posedge clock);
    if (exp_v && dout_r) begin
      mdl_fire++;
      for (int i = 0; i < NUM_IN; i++) void'(mdl_q[i].pop_front());
    end
    if (exp_v && !dout_r) mdl_stall++;
    last_push = din_v & exp_r;
    for (int i = 0; i < NUM_IN; i++)
      if (last_push[i]) mdl_q[i].push_back(din[i*DATA_W +: DATA_W]);
    @(negedge clock);
  endtask

  // Asynchronous reset between clock edges; outputs must clear before any edge.
  task automatic mid_reset(input string tag);
    #2 reset = 1'b0;
    #1;
    check({tag, "_dout_v"}, io_dout_v, 1'b0);
    check({tag, "_din_r"}, io_din_r, {NUM_IN{1'b1}});
    check({tag, "_dout"}, io_dout, '0);
`ifdef JOIN_STATS_EN
    check({tag, "_fire_cnt"}, io_fire_cnt, 0);
    check({tag, "_stall_cnt"}, io_stall_cnt, 0);
`endif
    for (int i = 0; i < NUM_IN; i++) mdl_q[i].delete();
    mdl_fire  = 0;
    mdl_stall = 0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    logic [DATA_W-1:0] nxt [NUM_IN];
    logic [NUM_IN*DATA_W-1:0] din;
    int fires_before;

    reset     = 1'b0;
    io_din    = '1;
    io_din_v  = '1;
    io_dout_r = 1'b0;

    // Reset held with valid inputs: nothing may be stored.
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("rst_din_r", io_din_r, {NUM_IN{1'b1}});
      check("rst_dout_v", io_dout_v, 1'b0);
      check("rst_dout", io_dout, '0);
    end
    reset = 1'b1;
    step(2'b00, '0, 1'b0);

    // First push after release visible one cycle later.
    step(2'b11, 16'h3456, 1'b0);
    check("first_head_v", io_dout_v, 1'b1);
    check("first_head", io_dout, 16'h3456);
    step(2'b00, '0, 1'b1);

    // Basic join: ch0 at cycle 0, ch1 at cycle 3, join at cycle 4.
    step(2'b01, 16'h0011, 1'b1);
    step(2'b00, '0, 1'b1);
    step(2'b00, '0, 1'b1);
    check("basic_v_early", io_dout_v, 1'b0);
    step(2'b10, 16'h2200, 1'b1);
    check("basic_v", io_dout_v, 1'b1);
    check("basic_dout", io_dout, 16'h2211);
    step(2'b00, '0, 1'b1);
    check("basic_popped", io_dout_v, 1'b0);

    // Backpressure: ch0 fills, third token held by the producer.
    step(2'b11, 16'hB0A0, 1'b0);
    step(2'b01, 16'h00A1, 1'b0);
    check("bp_full", io_din_r[0], 1'b0);
    check("bp_head", io_dout, 16'hB0A0);
    step(2'b01, 16'h00A2, 1'b1);
    step(2'b11, 16'hB1A2, 1'b1);
    check("bp_second", io_dout, 16'hB1A1);
    for (int c = 0; c < 4; c++) step(2'b00, '0, 1'b1);

    // Sustained throughput: one token set per cycle.
    fires_before = fire_seen;
    for (int c = 0; c < 16; c++) step(2'b11, {c[7:0], c[7:0]}, 1'b1);
    step(2'b00, '0, 1'b1);
    check("thru_fires", fire_seen - fires_before, 16);

    // Random valid/ready across many pointer wraps.
    for (int i = 0; i < NUM_IN; i++) nxt[i] = DATA_W'($urandom);
    fires_before = fire_seen;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NUM_IN; i++) din[i*DATA_W +: DATA_W] = nxt[i];
      step(NUM_IN'($urandom), din, 1'($urandom));
      for (int i = 0; i < NUM_IN; i++) if (last_push[i]) nxt[i] = nxt[i] + 8'd1;
    end
    check("wrap_enough_fires", (fire_seen - fires_before) >= 5 * DEPTH, 1'b1);

    // Reset mid-run with tokens stored.
    step(2'b11, 16'h5A5A, 1'b0);
    mid_reset("midrst");
    step(2'b00, '0, 1'b1);

`ifdef JOIN_STATS_EN
    // 4 stall cycles then 10 fires.
    step(2'b11, 16'h0102, 1'b0);
    for (int c = 0; c < 4; c++) step(2'b00, '0, 1'b0);
    for (int c = 0; c < 9; c++) step(2'b11, {c[7:0], c[7:0]}, 1'b1);
    step(2'b00, '0, 1'b1);
    #1;
    check("stats_fire10", io_fire_cnt, 10);
    check("stats_stall4", io_stall_cnt, 4);
    mid_reset("statsrst");
    step(2'b00, '0, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/join_buf.md
Name: join_buf

Overview:
- N-input elastic join for the CGRA dataflow fabric.
- Generalises the 2-input combinational join to NUM_IN channels of width DATA_W.
- Each channel gets its own DEPTH-entry FIFO, so producers run decoupled and din ready no longer depends combinationally on dout_r.
- A token set is emitted only when every channel holds a token; all channels pop together.

Parameters:
- NUM_IN, 2: number of joined channels (2..8).
- DATA_W, 8: data width per channel.
- DEPTH, 2: entries per channel FIFO; power of two, at least 2.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- io_din  in  NUM_IN*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- io_din_v  in  NUM_IN  per-channel valid.
- io_din_r  out  NUM_IN  per-channel ready.
- io_dout  out  NUM_IN*DATA_W  FIFO head of each channel, same packing as io_din.
- io_dout_v  out  1  joined valid.
- io_dout_r  in  1  downstream ready.
- io_fire_cnt  out  32  present only with JOIN_STATS_EN.
- io_stall_cnt  out  32  present only with JOIN_STATS_EN.

Behaviour:
- Reset (reset low, asynchronous):
  - All FIFO read/write pointers and counts clear to 0.
  - io_dout_v = 0; io_din_r = all ones; io_dout = 0.
  - Counters clear to 0.
  - Reset mid-operation discards all stored tokens immediately.
- Channel FIFO:
  - Pointers have log2(DEPTH)+1 bits; the MSB is the wrap bit.
  - full[i] = (MSB differs) & (low bits equal); empty[i] = pointers equal.
- io_din_r[i] = !full[i]. Registered-state only; no combinational path from io_dout_r or any other channel.
- push[i] = io_din_v[i] & io_din_r[i]. Writes data at the write pointer, then the write pointer increments, wrapping modulo 2*DEPTH.
- io_dout_v = AND over i of !empty[i].
- io_dout slice i = mem_i[rd_ptr_i]. Combinational from state; it holds stale memory contents when empty.
- fire = io_dout_v & io_dout_r.
  - On fire, every FIFO pops (read pointer +1).
  - No FIFO pops without fire.
- Latency: a token pushed at edge t is visible at the head from t+1. Minimum in-to-out latency is 1 cycle.
- Throughput: 1 token set per cycle sustained with DEPTH >= 2.
- Simultaneous push and pop on the same FIFO:
  - Allowed when not full; the count is unchanged.
  - When full, push is blocked (ready = 0) even if a pop occurs that cycle. This keeps ready registered.
- Empty FIFO plus push, with other channels non-empty: io_dout_v rises the next cycle, never in the same cycle.
- io_dout_r high with io_dout_v low: no effect.
- io_dout_v must stay high and io_dout stable until fire. This holds by construction because pops happen only on fire.

Optional Feature:
- Macro: JOIN_STATS_EN.
- Defined:
  - io_fire_cnt increments on each fire.
  - io_stall_cnt increments each cycle with io_dout_v & !io_dout_r.
  - Both counters are 32-bit, saturate at 0xFFFFFFFF, and reset to 0.
- Undefined: both ports and their counters are absent; the rest of the behaviour is identical.

Decomposition:
- Package join_pkg holds:
  - function clog2_f;
  - localparam-style helper for pointer width (PTR_W = clog2(DEPTH)+1);
  - constant CNT_W = 32.
- Sub-module join_fifo (DATA_W, DEPTH) holds mem, pointers, full/empty, push/pop.
  - Instantiated NUM_IN times in a generate loop.
  - The top holds the join AND, fire, pop fan-out and the optional counters.

Test Plan:
- Reset: hold reset low 3 cycles with io_din_v all ones -> io_din_r=all ones, io_dout_v=0, nothing stored. First push after release appears at the head 1 cycle later.
- Basic join, NUM_IN=2:
  - Push ch0=0x11 at cycle 0; ch1=0x22 at cycle 3; dout_r=1.
  - Required: io_dout_v=0 through cycle 3, 1 at cycle 4 with io_dout={0x22,0x11}; pops at cycle 4 end.
- Backpressure / full, DEPTH=2:
  - dout_r=0; push 0xA0, 0xA1, 0xA2 on ch0 and 0xB0 on ch1.
  - Required: io_din_r[0]=0 after two pushes; 0xA2 held by the producer.
  - Release dout_r -> outputs in order {0xB0,0xA0}, then {next ch1,0xA1}.
- Sustained throughput:
  - Both channels valid every cycle with values 0..15, dout_r=1.
  - Required: 16 fires in 16 consecutive cycles after the first; order and pairing preserved; io_din_r never drops.
- Wrap-around: 5*DEPTH tokens with random dout_r and random din_v -> scoreboard matches exactly; no loss or duplication across pointer wrap.
- JOIN_STATS_EN: 10 fires plus 4 stall cycles -> io_fire_cnt=10, io_stall_cnt=4. Asynchronous reset mid-run -> both read 0 immediately.
